// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// state encoding, default frame geometry and counter sizing helper.
package serial_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each
// bit period with tick and wraps to zero on that cycle.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit (0), DATA_BITS payload bits LSB first, one
// stop bit (1), each held for CLKS_PER_BIT clocks. tx is a registered output.
//
//   state | meaning
//   IDLE  | line high, ready for a new word
//   START | start bit (tx = 0)
//   DATA  | payload bit shift_q[0] on the line
//   STOP  | stop bit (tx = 1), done on its last cycle
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BW = cnt_width(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic [BW-1:0]        bit_cnt, bit_cnt_next;
  logic                 tx_next;
  logic                 tick;
  logic                 timer_clear;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt;
    timer_clear  = 1'b0;
    tx_next      = 1'b1;

    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (valid) begin
          state_next   = START;
          shift_next   = data;
          bit_cnt_next = '0;
        end
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
            shift_next   = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM is heading.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign ready = (state == IDLE) && !rst;
  assign busy  = (state != IDLE) && !rst;
  assign done  = (state == STOP) && tick && !rst;

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
REQ-002 SHALL have parameter DATA_BITS, default 8: payload bits per frame; legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port data, input, DATA_BITS bits: parallel word to transmit.
REQ-006 SHALL have port valid, input, 1 bit: data is offered.
REQ-007 SHALL have port ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 SHALL drive ready = 1 only in IDLE with rst low; busy SHALL equal the inverse of ready outside reset.
REQ-013 SHALL accept a word at the rising edge where valid && ready, latching data into a shift register and entering START.
REQ-014 SHALL ignore changes to data and valid after acceptance until the next IDLE.
REQ-015 SHALL register tx; tx SHALL be 0 from the first cycle after acceptance for exactly CLKS_PER_BIT cycles (START).
REQ-016 SHALL in DATA drive payload LSB first, each bit for exactly CLKS_PER_BIT cycles, using a bit counter 0..DATA_BITS-1.
REQ-017 SHALL in STOP drive tx = 1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 SHALL pulse done high for exactly the last STOP cycle.
REQ-019 SHALL make the frame exactly (DATA_BITS+2)*CLKS_PER_BIT cycles, with no idle cycle inserted by the block itself.
REQ-020 SHALL support back-to-back frames: ready is 1 in the cycle after done, so a word held on valid starts START one cycle after that, giving exactly one idle-high cycle between frames.
REQ-021 SHALL keep tx = 1 in IDLE regardless of valid.
REQ-022 SHALL, with CLKS_PER_BIT = 1, drive each bit for a single cycle with no glitch or skipped bit.
REQ-023 SHALL size the bit-period counter to hold CLKS_PER_BIT-1 and wrap it to 0 at each bit boundary; no counter overflow.

Reset
REQ-024 SHALL in any cycle with rst high force state IDLE, tx = 1, ready = 0, busy = 0, done = 0, and clear both counters and the shift register.
REQ-025 SHALL abort a frame when rst is asserted mid-frame; tx SHALL be 1 from the edge that samples rst, and no done pulse SHALL follow.
REQ-026 SHALL ignore valid while rst is high; ready SHALL be 1 in the first cycle after rst falls.

Structure
REQ-027 SHALL place the state encoding (2-bit IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT and DATA_BITS values in shared package serial_pkg, for reuse by the matching receiver.
REQ-028 SHALL implement the bit-period counter as sub-module bit_timer (inputs clk, rst, clear; output tick when the count reaches CLKS_PER_BIT-1).

Verification
REQ-029 SHALL cover: defaults, data=8'hA5 accepted at cycle 0 -> tx 0 for cycles 1-4, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for cycles 37-40; done high at cycle 40 only.
REQ-030 SHALL cover: valid held high with 8'h00 then 8'hFF -> frames of 40 cycles each, exactly 1 idle-high cycle between them, ready high only in that gap.
REQ-031 SHALL cover: rst asserted at cycle 15 of a frame -> tx = 1 and ready = 0 during reset, ready = 1 the cycle after release, no done pulse.
REQ-032 SHALL cover: CLKS_PER_BIT=1, DATA_BITS=4, data=4'b1001 -> tx sequence 0,1,0,0,1,1 over 6 cycles, done on the 6th.
REQ-033 SHALL cover: data changed from 8'h3C to 8'hC3 one cycle after acceptance -> serial payload remains 8'h3C.
REQ-034 SHALL cover: valid low for 100 cycles after reset -> tx constantly 1, busy 0, done never asserted.
